inst_encoder: RTL and testbench

Streaming MIPS instruction encoder, the inverse of the control decoder. It accepts symbolic instruction requests (mnemonic code plus fields) over a valid/ready handshake. Each request becomes a 32-bit MIPS word, which the block writes sequentially into instruction memory through a valid/ready write port. Used by the self-test loader to build programs in IMEM without an external assembler.

---
 rtl/inst_enc_pkg.sv | 55 +++++
 rtl/inst_enc_fmt.sv | 62 ++++++
 rtl/inst_encoder.sv | 147 ++++++++++++++
 tb/tb_inst_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_enc_pkg.sv
// Shared types for the MIPS instruction encoder: mnemonic codes, opcode/funct
// constants, FSM states and word-assembly helpers.
package inst_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3,
    OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_NOR  = 5'd6,  OP_SLT  = 5'd7,
    OP_SLTU = 5'd8,  OP_JR   = 5'd9,  OP_ADDI = 5'd10, OP_ORI  = 5'd11,
    OP_LW   = 5'd12, OP_SW   = 5'd13, OP_BEQ  = 5'd14, OP_BNE  = 5'd15,
    OP_J    = 5'd16, OP_JAL  = 5'd17
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2,
    S_PAD  = 2'd3
  } state_e;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] tgt);
    return {opc, tgt};
  endfunction

endpackage

// File: rtl/inst_enc_fmt.sv
// Combinational mnemonic-to-word mapping; flags unsupported codes and
// control-transfer instructions (which need a delay slot when padding is on).
module inst_enc_fmt
  import inst_enc_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        valid_op_o,
  output logic        is_branch_o
);

  op_e op;
  assign op = op_e'(op_i);

  always_comb begin
    word_o      = '0;
    valid_op_o  = 1'b1;
    is_branch_o = 1'b0;
    case (op)
      OP_ADD:  word_o = enc_r(rs_i, rt_i, rd_i, FN_ADD);
      OP_ADDU: word_o = enc_r(rs_i, rt_i, rd_i, FN_ADDU);
      OP_SUB:  word_o = enc_r(rs_i, rt_i, rd_i, FN_SUB);
      OP_SUBU: word_o = enc_r(rs_i, rt_i, rd_i, FN_SUBU);
      OP_AND:  word_o = enc_r(rs_i, rt_i, rd_i, FN_AND);
      OP_OR:   word_o = enc_r(rs_i, rt_i, rd_i, FN_OR);
      OP_NOR:  word_o = enc_r(rs_i, rt_i, rd_i, FN_NOR);
      OP_SLT:  word_o = enc_r(rs_i, rt_i, rd_i, FN_SLT);
      OP_SLTU: word_o = enc_r(rs_i, rt_i, rd_i, FN_SLTU);
      OP_JR: begin
        word_o      = enc_r(rs_i, 5'd0, 5'd0, FN_JR);
        is_branch_o = 1'b1;
      end
      OP_ADDI: word_o = enc_i(OPC_ADDI, rs_i, rt_i, imm_i);
      OP_ORI:  word_o = enc_i(OPC_ORI,  rs_i, rt_i, imm_i);
      OP_LW:   word_o = enc_i(OPC_LW,   rs_i, rt_i, imm_i);
      OP_SW:   word_o = enc_i(OPC_SW,   rs_i, rt_i, imm_i);
      OP_BEQ: begin
        word_o      = enc_i(OPC_BEQ, rs_i, rt_i, imm_i);
        is_branch_o = 1'b1;
      end
      OP_BNE: begin
        word_o      = enc_i(OPC_BNE, rs_i, rt_i, imm_i);
        is_branch_o = 1'b1;
      end
      OP_J: begin
        word_o      = enc_j(OPC_J, target_i);
        is_branch_o = 1'b1;
      end
      OP_JAL: begin
        word_o      = enc_j(OPC_JAL, target_i);
        is_branch_o = 1'b1;
      end
      default: valid_op_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming MIPS instruction encoder writing sequential words into IMEM.
// Define INST_ENC_DELAY_PAD_EN to append a NOP delay slot after each branch/jump.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

`ifdef INST_ENC_DELAY_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_data_q, out_data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic                pad_pend_q, pad_pend_d;

  logic [31:0] fmt_word;
  logic        fmt_valid, fmt_branch;
  logic        room, accept, wr;

  inst_enc_fmt u_fmt (
    .op_i       (in_op),
    .rs_i       (in_rs),
    .rt_i       (in_rt),
    .rd_i       (in_rd),
    .imm_i      (in_imm),
    .target_i   (in_target),
    .word_o     (fmt_word),
    .valid_op_o (fmt_valid),
    .is_branch_o(fmt_branch)
  );

  // Never accept a word that could not be written before DEPTH is reached,
  // and hold off while a delay-slot NOP is still owed.
  assign room     = out_valid_q ? (count_q < LAST_C) : (count_q < DEPTH_C);
  assign in_ready = (state_q == S_RUN) & (~out_valid_q | out_ready) & ~start
                  & room & ~pad_pend_q;
  assign accept   = in_valid & in_ready;
  assign wr       = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    addr_d      = addr_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    pad_pend_d  = pad_pend_q;
    if (start) begin
      state_d     = S_RUN;
      out_valid_d = 1'b0;
      addr_d      = '0;
      count_d     = '0;
      full_d      = 1'b0;
      err_d       = 1'b0;
      pad_pend_d  = 1'b0;
    end else begin
      if (wr) begin
        out_valid_d = 1'b0;
        pad_pend_d  = 1'b0;
        count_d     = count_q + (ADDR_W+1)'(1);
        // Saturate rather than wrap when DEPTH spans the whole address space.
        if (addr_q != '1) addr_d = addr_q + ADDR_W'(1);
        if (count_q == LAST_C) begin
          full_d  = 1'b1;
          state_d = S_FULL;
        end else if (pad_pend_q) begin
          state_d     = S_PAD;
          out_valid_d = 1'b1;
          out_data_d  = '0;
        end else if (state_q == S_PAD) begin
          state_d = S_RUN;
        end
      end
      if (accept) begin
        if (fmt_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = fmt_word;
          pad_pend_d  = PAD_EN & fmt_branch;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      pad_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
      pad_pend_q  <= pad_pend_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of the expected IMEM write stream.
module tb_inst_encoder;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
`ifdef INST_ENC_DELAY_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic              clk, rstn, start, in_valid, in_ready;
  logic [4:0]        in_op, in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid, out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_data;
  logic              full, err;
  logic [ADDR_W:0]   count;

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .full(full), .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the instruction-format tables.
  function automatic logic [31:0] ref_enc(input int op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt);
    logic [5:0] f;
    logic [5:0] o;
    f = 6'h00;
    o = 6'h00;
    case (op)
      0: f = 6'h20;  1: f = 6'h21;  2: f = 6'h22;  3: f = 6'h23;  4: f = 6'h24;
      5: f = 6'h25;  6: f = 6'h27;  7: f = 6'h2A;  8: f = 6'h2B;  9: f = 6'h08;
      10: o = 6'h08; 11: o = 6'h0D; 12: o = 6'h23; 13: o = 6'h2B;
      14: o = 6'h04; 15: o = 6'h05; 16: o = 6'h02; 17: o = 6'h03;
      default: ;
    endcase
    if (op == 9)  return {6'd0, rs, 10'd0, 5'd0, f};
    if (op < 9)   return {6'd0, rs, rt, rd, 5'd0, f};
    if (op < 16)  return {o, rs, rt, imm};
    return {o, tgt};
  endfunction

  function automatic bit is_br(input int op);
    return (op == 9) || (op == 14) || (op == 15) || (op == 16) || (op == 17);
  endfunction

  // Model: pending words awaiting write, words written, session/err flags.
  logic [31:0] mq[$];
  bit          mpad[$];
  int          m_cnt = 0;
  bit          m_run = 1'b0;
  bit          m_err = 1'b0;

  always @(negedge clk) begin
    bit pad_owed;
    bit exp_rdy;
    if (!rstn) begin
      mq.delete(); mpad.delete();
      m_cnt = 0; m_run = 1'b0; m_err = 1'b0;
    end else begin
      pad_owed = 1'b0;
      foreach (mpad[i]) if (mpad[i]) pad_owed = 1'b1;
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("err", 32'(err), 32'(m_err));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (out_valid && mq.size() != 0) begin
        chk("out_data", out_data, mq[0]);
        chk("out_addr", 32'(out_addr), 32'(m_cnt));
      end
      exp_rdy = m_run && !start && (!out_valid || out_ready) && !pad_owed
                && (m_cnt + mq.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (start) begin
        mq.delete(); mpad.delete();
        m_cnt = 0; m_err = 1'b0; m_run = 1'b1;
      end else begin
        if (out_valid && out_ready && mq.size() != 0) begin
          void'(mq.pop_front()); void'(mpad.pop_front());
          m_cnt++;
        end
        if (in_valid && in_ready) begin
          if (int'(in_op) < 18) begin
            mq.push_back(ref_enc(int'(in_op), in_rs, in_rt, in_rd, in_imm, in_target));
            mpad.push_back(1'b0);
            if (PAD_EN && is_br(int'(in_op)) && (m_cnt + mq.size() < DEPTH)) begin
              mq.push_back(32'h0); mpad.push_back(1'b1);
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input int imm, input int tgt);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    tick(); rstn = 1'b1;
    tick(); tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // add rd=3 rs=1 rt=2
    out_ready = 1'b1;
    do_start();
    send(0, 1, 2, 3, 0, 0);
    chk("add_word", out_data, 32'h00221820);
    chk("add_addr", 32'(out_addr), 32'd0);
    tick();
    chk("add_count", 32'(count), 32'd1);

    // addi then lw under a 3-cycle stall
    do_start();
    out_ready = 1'b0;
    send(10, 0, 8, 0, 16'h0005, 0);
    in_valid = 1'b1; in_op = 5'd12; in_rs = 5'd29; in_rt = 5'd9; in_imm = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold", out_data, 32'h20080005);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lw_word", out_data, 32'h8FA90004);
    chk("lw_addr", 32'(out_addr), 32'd1);
    tick(); tick();

    // jal
    do_start();
    send(17, 0, 0, 0, 0, 26'h0000100);
    chk("jal_word", out_data, 32'h0C000100);
    tick(); tick(); tick();

    // unsupported op, then normal op, then start clears err
    do_start();
    send(20, 1, 2, 3, 16'h1234, 0);
    chk("bad_no_valid", 32'(out_valid), 32'd0);
    chk("bad_err", 32'(err), 32'd1);
    send(11, 1, 2, 0, 16'hABCD, 0);
    chk("ori_word", out_data, 32'h3422ABCD);
    chk("err_sticky", 32'(err), 32'd1);
    tick();
    do_start();
    chk("start_clr_err", 32'(err), 32'd0);

    // fill to DEPTH, fifth request refused
    send(1, 4, 5, 6, 0, 0);
    send(12, 7, 8, 0, 16'h0010, 0);
    send(13, 9, 10, 0, 16'hFFF0, 0);
    send(6, 11, 12, 13, 0, 0);
    in_valid = 1'b1; in_op = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_no_accept", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'(DEPTH));

    // async reset during a stall
    do_start();
    out_ready = 1'b0;
    send(2, 3, 4, 5, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    tick(); tick(); rstn = 1'b1;
    tick(); tick();
    chk("post_rst_idle", 32'(in_ready), 32'd0);

    // randomized traffic
    do_start();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_op     = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 18)) : 5'($urandom_range(17));
      in_rs     = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      in_imm    = 16'($urandom); in_target = 26'($urandom);
      out_ready = ($urandom_range(3) != 0);
      start     = ($urandom_range(29) == 0);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
